mips_cpu_regwrite_arbiter: RTL and testbench
============================================

Name: mips_cpu_regwrite_arbiter

Overview:
Shares the register file's single write port between two requesters.
- The execute-stage result, which has priority.
- Load data returning from the memory interface, with a valid/ready handshake and a small FIFO.
It also keeps a per-register scoreboard of outstanding loads, so decode can detect read-after-load hazards.
It sits between the execute and memory-return paths and the register file's write, wrAddr and wrData inputs.

Parameters:
FIFO_DEPTH, 2, load-return buffer entries; power of two, at least 2.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state
exec_valid  input  1  execute stage has a result to write this cycle
exec_addr  input  5  destination register of the execute result
exec_data  input  32  execute result
load_issue  input  1  a load was issued this cycle; mark its destination pending
load_issue_addr  input  5  destination of the issued load
load_valid  input  1  load return data present
load_ready  output  1  arbiter can accept load return data
load_addr  input  5  destination of the returning load
load_data  input  32  returning load data
write  output  1  register file write enable (registered)
wrAddr  output  5  register file write address (registered)
wrData  output  32  register file write data (registered)
chkAddrA  input  5  decode read address A to check
chkAddrB  input  5  decode read address B to check
hazardA  output  1  chkAddrA has an outstanding or in-flight load write
hazardB  output  1  chkAddrB has an outstanding or in-flight load write

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values:
  - write=0, wrAddr=0, wrData=0.
  - FIFO empty; pending vector all zero.
  - load_ready=0 in any cycle where reset=1.
- Load handshake:
  - load_ready = !reset && (fifo_count < FIFO_DEPTH), combinational.
  - A load is accepted when load_valid && load_ready.
  - load_ready does not depend on load_valid.
- Per-cycle selection, in strict priority order:
  1. exec_valid with exec_addr != 0 → exec.
  2. FIFO non-empty → pop head.
  3. Load accepted this cycle with FIFO empty → direct bypass.
  4. Otherwise no write.
- The winner is registered: write=1, wrAddr and wrData update at the next edge, giving 1-cycle latency to the register file port.
- If no winner, write=0 at the next edge; wrAddr and wrData hold their values.
- An accepted load that is not bypassed is pushed to the FIFO tail in the same cycle.
- Push and pop in the same cycle are allowed; count is unchanged.
- Pushing when full cannot happen, because load_ready is 0.
- Register 0:
  - An exec with exec_addr=0 is dropped and does not consume the slot; lower priorities still get it.
  - An accepted load with load_addr=0 is discarded: never pushed, never written.
  - load_issue with addr 0 sets nothing.
- Scoreboard: 32-bit pending vector; bit 0 is always 0.
  - load_issue sets pending[load_issue_addr] at the next edge.
  - A load-sourced selection clears pending[addr] at the next edge; exec-sourced writes never touch pending.
  - If set and clear target the same register in the same cycle, set wins.
- Hazard outputs (combinational):
  - hazardX = pending[chkAddrX] || (write && wrAddr == chkAddrX && chkAddrX != 0).
  - The second term covers the cycle in which the register file has not yet committed the write.
- Ordering:
  - Loads write in acceptance order.
  - An exec result always preempts queued loads. WAW ordering between exec and loads is the CPU's responsibility.
- Reset mid-operation drops FIFO contents and pending bits; no write is emitted in the cycle after reset.

Decomposition:
- Shared package mips_cpu_pkg:
  - reg_addr_t (5-bit) and word_t (32-bit) typedefs.
  - REG_ZERO = 5'd0 constant.
  - NUM_REGS = 32 constant.
- One sub-module, mips_cpu_wb_fifo: FIFO_DEPTH entries of {reg_addr_t, word_t}.
  - Ports: push, pop, full, empty, count.
  - Circular read/write pointers with wrap-around.
  - Synchronous reset.

Test Plan:
- Reset, then idle → write=0, load_ready=1, hazardA=hazardB=0 with all checks at any address.
- exec_valid=1, exec_addr=5, exec_data=0x1234 in cycle N → write=1, wrAddr=5, wrData=0x1234 in cycle N+1; write=0 in N+2.
- load_issue for register 8, then load return (8, 0xCAFE) with exec idle:
  - hazardA=1 with chkAddrA=8 from the edge after issue, and stays 1 through the cycle in which write=1, wrAddr=8.
  - hazardA=0 in the cycle after that.
- exec_valid=1 (reg 3) for 3 consecutive cycles while loads (9, 0xA), (10, 0xB), (11, 0xC) are offered:
  - Loads 9 and 10 are accepted; load_ready=0 on the third offer.
  - Write sequence: reg 3 ×3, then 9/0xA, 10/0xB, then 11/0xC after it is accepted.
- exec_addr=0 with a simultaneous load (4, 0x77) → exec dropped; write=1, wrAddr=4, wrData=0x77 next cycle. A load return to register 0 is accepted with no write.
- FIFO holding 2 entries, pending bits set, reset=1 for one cycle → after reset: write=0, FIFO empty, all hazards 0, load_ready=1.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types for the register-file write-back path.
//   reg_addr_t : architectural register index
//   word_t     : data word
//   wb_entry_t : one buffered write {addr, data}
//   wb_src_e   : which requester owns the write port in a given cycle
package mips_cpu_pkg;

    localparam int unsigned NUM_REGS = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef struct packed {
        reg_addr_t addr;
        word_t     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SrcNone,
        SrcExec,
        SrcFifo,
        SrcBypass
    } wb_src_e;

endpackage

// File: rtl/mips_cpu_wb_fifo.sv
// Small circular FIFO buffering returning load writes.
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i, push_entry_i : enqueue an entry at the tail
//   pop_i, head_o  : dequeue; head_o is the current head entry
//   full_o, empty_o, count_o : occupancy status
module mips_cpu_wb_fifo
    import mips_cpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            push_i,
    input  wb_entry_t       push_entry_i,
    input  logic            pop_i,
    output wb_entry_t       head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    wb_entry_t       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mips_cpu_regwrite_arbiter.sv
// Arbitrates the register file's single write port between the execute
// result (highest priority) and returning load data (buffered in a FIFO),
// and tracks outstanding loads per register for decode hazard checks.
//   clk, reset                     : clock, synchronous active-high reset
//   exec_valid/exec_addr/exec_data : execute-stage write request
//   load_issue/load_issue_addr     : marks a load destination pending
//   load_valid/load_ready/load_addr/load_data : load return handshake
//   write/wrAddr/wrData            : registered register-file write port
//   chkAddrA/B, hazardA/B          : read-after-load hazard queries
module mips_cpu_regwrite_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exec_valid,
    input  logic [4:0]  exec_addr,
    input  logic [31:0] exec_data,
    input  logic        load_issue,
    input  logic [4:0]  load_issue_addr,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [4:0]  load_addr,
    input  logic [31:0] load_data,
    output logic        write,
    output logic [4:0]  wrAddr,
    output logic [31:0] wrData,
    input  logic [4:0]  chkAddrA,
    input  logic [4:0]  chkAddrB,
    output logic        hazardA,
    output logic        hazardB
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t       fifo_head;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;

    logic            load_acc, load_keep;
    wb_src_e         src;

    logic            write_q, write_d;
    reg_addr_t       wr_addr_q, wr_addr_d;
    word_t           wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    mips_cpu_wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .reset_i      (reset),
        .push_i       (fifo_push),
        .push_entry_i ('{addr: load_addr, data: load_data}),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    assign load_ready = !reset && (fifo_count < CntW'(FIFO_DEPTH));
    assign load_acc   = load_valid && load_ready;
    // Loads to r0 are accepted but go nowhere.
    assign load_keep  = load_acc && (load_addr != REG_ZERO);

    always_comb begin
        src       = SrcNone;
        fifo_pop  = 1'b0;
        if (exec_valid && exec_addr != REG_ZERO) begin
            src = SrcExec;
        end else if (!fifo_empty) begin
            src      = SrcFifo;
            fifo_pop = 1'b1;
        end else if (load_keep) begin
            src = SrcBypass;
        end
        fifo_push = load_keep && (src != SrcBypass);
    end

    always_comb begin
        write_d   = (src != SrcNone);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (src)
            SrcExec: begin
                wr_addr_d = exec_addr;
                wr_data_d = exec_data;
            end
            SrcFifo: begin
                wr_addr_d = fifo_head.addr;
                wr_data_d = fifo_head.data;
            end
            SrcBypass: begin
                wr_addr_d = load_addr;
                wr_data_d = load_data;
            end
            default: ;
        endcase

        pending_d = pending_q;
        if (src == SrcFifo || src == SrcBypass) begin
            pending_d[wr_addr_d] = 1'b0;
        end
        // A new issue to the same register overrides the clear.
        if (load_issue) begin
            pending_d[load_issue_addr] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            write_q   <= write_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    // load_ready gating must make an overflowing push impossible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(fifo_push && fifo_full));
        end
    end

    assign write  = write_q;
    assign wrAddr = wr_addr_q;
    assign wrData = wr_data_q;

    // Second term covers the cycle before the register file commits the write.
    assign hazardA = pending_q[chkAddrA] ||
                     (write_q && wr_addr_q == chkAddrA && chkAddrA != REG_ZERO);
    assign hazardB = pending_q[chkAddrB] ||
                     (write_q && wr_addr_q == chkAddrB && chkAddrB != REG_ZERO);

endmodule

// File: tb/tb_mips_cpu_regwrite_arbiter.sv
module tb_mips_cpu_regwrite_arbiter;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        exec_valid;
    logic [4:0]  exec_addr;
    logic [31:0] exec_data;
    logic        load_issue;
    logic [4:0]  load_issue_addr;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        write;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [4:0]  chkAddrA;
    logic [4:0]  chkAddrB;
    logic        hazardA;
    logic        hazardB;

    mips_cpu_regwrite_arbiter #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .exec_valid      (exec_valid),
        .exec_addr       (exec_addr),
        .exec_data       (exec_data),
        .load_issue      (load_issue),
        .load_issue_addr (load_issue_addr),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .write           (write),
        .wrAddr          (wrAddr),
        .wrData          (wrData),
        .chkAddrA        (chkAddrA),
        .chkAddrB        (chkAddrB),
        .hazardA         (hazardA),
        .hazardB         (hazardB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];     // scoreboard of expected register-file writes
    wr_t model_buf[$]; // reference: accepted loads waiting for the port
    bit  pend[32];
    bit  m_wr;
    logic [4:0] m_wr_addr;
    bit  chk_on;
    int  tests;
    int  fails;

    // Stimulus for the next cycle.
    bit          s_rst, s_ev, s_li, s_lv;
    logic [4:0]  s_ea, s_lia, s_la, s_ca, s_cb;
    logic [31:0] s_ed, s_ld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_stim();
        s_rst = 0; s_ev = 0; s_li = 0; s_lv = 0;
        s_ea = 0; s_lia = 0; s_la = 0; s_ca = 0; s_cb = 0;
        s_ed = 0; s_ld = 0;
    endtask

    // Apply stimulus for one cycle, check combinational outputs, advance model.
    task automatic cycle(output bit acc);
        bit  exp_ready, have, from_load, bypass;
        bit  exp_ha, exp_hb;
        wr_t w;
        @(negedge clk);
        reset = s_rst; exec_valid = s_ev; exec_addr = s_ea; exec_data = s_ed;
        load_issue = s_li; load_issue_addr = s_lia;
        load_valid = s_lv; load_addr = s_la; load_data = s_ld;
        chkAddrA = s_ca; chkAddrB = s_cb;
        #1;
        exp_ready = !s_rst && (model_buf.size() < DEPTH);
        check("load_ready", load_ready, exp_ready);
        acc = s_lv && exp_ready;
        if (chk_on) begin
            exp_ha = pend[s_ca] || (m_wr && m_wr_addr == s_ca && s_ca != 0);
            exp_hb = pend[s_cb] || (m_wr && m_wr_addr == s_cb && s_cb != 0);
            check("write_en", write, m_wr);
            check("hazardA", hazardA, exp_ha);
            check("hazardB", hazardB, exp_hb);
        end
        if (s_rst) begin
            model_buf.delete();
            foreach (pend[i]) pend[i] = 0;
            m_wr = 0;
            m_wr_addr = 0;
        end else begin
            have = 0; from_load = 0; bypass = 0;
            w = '{a: 5'd0, d: 32'd0};
            if (s_ev && s_ea != 0) begin
                w = '{a: s_ea, d: s_ed}; have = 1;
            end else if (model_buf.size() > 0) begin
                w = model_buf.pop_front(); have = 1; from_load = 1;
            end else if (acc && s_la != 0) begin
                w = '{a: s_la, d: s_ld}; have = 1; from_load = 1; bypass = 1;
            end
            if (acc && s_la != 0 && !bypass) model_buf.push_back('{a: s_la, d: s_ld});
            if (have) begin
                exp_q.push_back(w);
                m_wr_addr = w.a;
                if (from_load) pend[w.a] = 0;
            end
            m_wr = have;
            if (s_li && s_lia != 0) pend[s_lia] = 1;
        end
    endtask

    // Monitor: compare each presented write against the scoreboard head.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected none at %0t",
                             wrAddr, wrData, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wrAddr", wrAddr, e.a);
                    check("wrData", wrData, e.d);
                end
            end
        end
    end

    initial begin
        bit acc;
        bit off_v;
        logic [4:0]  off_a;
        logic [31:0] off_d;
        wr_t offers[$];
        tests = 0; fails = 0; chk_on = 0;
        m_wr = 0; m_wr_addr = 0;
        foreach (pend[i]) pend[i] = 0;

        // Reset, then idle with hazard queries at assorted addresses.
        idle_stim(); s_rst = 1;
        cycle(acc); cycle(acc);
        chk_on = 1;
        for (int i = 0; i < 4; i++) begin
            idle_stim(); s_ca = 5'(i * 7); s_cb = 5'(31 - i);
            cycle(acc);
        end

        // Single exec write.
        idle_stim(); s_ev = 1; s_ea = 5; s_ed = 32'h1234; cycle(acc);
        idle_stim(); cycle(acc);
        idle_stim(); cycle(acc);

        // Load issue to r8, then return; hazard tracked throughout.
        idle_stim(); s_li = 1; s_lia = 8; s_ca = 8; cycle(acc);
        idle_stim(); s_ca = 8; cycle(acc);
        idle_stim(); s_ca = 8; s_lv = 1; s_la = 8; s_ld = 32'hCAFE; cycle(acc);
        idle_stim(); s_ca = 8; cycle(acc);
        idle_stim(); s_ca = 8; cycle(acc);

        // Exec to r3 for three cycles while loads 9,10,11 are offered and held.
        offers.push_back('{a: 5'd9,  d: 32'hA});
        offers.push_back('{a: 5'd10, d: 32'hB});
        offers.push_back('{a: 5'd11, d: 32'hC});
        for (int i = 0; i < 10; i++) begin
            idle_stim();
            s_ca = 9; s_cb = 11;
            if (i < 3) begin s_ev = 1; s_ea = 3; s_ed = 32'(100 + i); end
            if (offers.size() > 0) begin
                s_lv = 1; s_la = offers[0].a; s_ld = offers[0].d;
            end
            cycle(acc);
            if (acc) void'(offers.pop_front());
        end

        // exec to r0 alongside a load to r4; then a load to r0.
        idle_stim(); s_ev = 1; s_ea = 0; s_ed = 32'hDEAD; s_lv = 1; s_la = 4; s_ld = 32'h77;
        cycle(acc);
        idle_stim(); s_lv = 1; s_la = 0; s_ld = 32'h55; cycle(acc);
        idle_stim(); cycle(acc);

        // Fill the FIFO with pending bits set, then reset for one cycle.
        idle_stim(); s_li = 1; s_lia = 12; cycle(acc);
        idle_stim(); s_li = 1; s_lia = 13; cycle(acc);
        idle_stim(); s_ev = 1; s_ea = 2; s_ed = 32'h1; s_lv = 1; s_la = 12; s_ld = 32'h12;
        cycle(acc);
        idle_stim(); s_ev = 1; s_ea = 2; s_ed = 32'h2; s_lv = 1; s_la = 13; s_ld = 32'h13;
        s_ca = 12; s_cb = 13;
        cycle(acc);
        idle_stim(); s_rst = 1; s_ca = 12; s_cb = 13; cycle(acc);
        for (int i = 0; i < 3; i++) begin
            idle_stim(); s_ca = 12; s_cb = 13; cycle(acc);
        end

        // Randomized traffic with held load offers.
        off_v = 0; off_a = 0; off_d = 0;
        for (int i = 0; i < 3000; i++) begin
            idle_stim();
            s_rst = ($urandom_range(0, 199) == 0);
            s_ev  = ($urandom_range(0, 9) < 4);
            s_ea  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            s_ed  = $urandom;
            s_li  = ($urandom_range(0, 3) == 0);
            s_lia = 5'($urandom_range(0, 7));
            if (!off_v && $urandom_range(0, 2) != 0) begin
                off_v = 1;
                off_a = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
                off_d = $urandom;
            end
            s_lv = off_v; s_la = off_a; s_ld = off_d;
            s_ca = 5'($urandom_range(0, 7));
            s_cb = 5'($urandom_range(0, 31));
            cycle(acc);
            if (acc || s_rst) off_v = 0;
        end

        for (int i = 0; i < 5; i++) begin
            idle_stim(); cycle(acc);
        end
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
